// File: rtl/bob_retire_pkg.sv
// Shared sizing for the branch order buffer retire end.
// The values mirror the `bob_width / `bob_addr_width / `bob_count macros.
package bob_retire_pkg;

    localparam int BOB_WIDTH      = 32;
    localparam int BOB_ADDR_WIDTH = 6;
    localparam int BOB_COUNT      = 48;

    typedef struct packed {
        logic [BOB_ADDR_WIDTH-1:0] addr;
        logic [BOB_WIDTH-1:0]      data;
    } bob_out_t;

endpackage

// File: rtl/bob_retire_if.sv
// Allocator, BOB RAM read port, completion marks and retire output as one bundle.
// master = retire block, slave = its surroundings.
interface bob_retire_if #(
    parameter int WIDTH      = bob_retire_pkg::BOB_WIDTH,
    parameter int ADDR_WIDTH = bob_retire_pkg::BOB_ADDR_WIDTH
);
    logic                  except;
    logic                  hasRetire;
    logic [ADDR_WIDTH-1:0] retire_addr;
    logic                  doRetire;
    logic                  read_clkEn;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [WIDTH-1:0]      read_data;
    logic                  done_en;
    logic [ADDR_WIDTH-1:0] done_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [ADDR_WIDTH-1:0] out_addr;

    modport master (
        input  except, hasRetire, retire_addr, read_data, done_en, done_addr, out_ready,
        output doRetire, read_clkEn, read_addr, out_valid, out_data, out_addr
    );

    modport slave (
        output except, hasRetire, retire_addr, read_data, done_en, done_addr, out_ready,
        input  doRetire, read_clkEn, read_addr, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/bob_done_vec.sv
// Per-entry completion bits: indexed set, indexed clear, global clear, indexed read.
// Clears beat sets; indices at or above COUNT never match a bit.
module bob_done_vec
    import bob_retire_pkg::*;
#(
    parameter int COUNT      = BOB_COUNT,
    parameter int ADDR_WIDTH = BOB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_all,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_bit
);

    logic [COUNT-1:0] done;

    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            done <= '0;
        end else begin
            for (int i = 0; i < COUNT; i++) begin
                if (clr_en && clr_addr == ADDR_WIDTH'(i))
                    done[i] <= 1'b0;
                else if (set_en && set_addr == ADDR_WIDTH'(i))
                    done[i] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_bit = 1'b0;
        for (int i = 0; i < COUNT; i++)
            if (rd_addr == ADDR_WIDTH'(i)) rd_bit = done[i];
    end

endmodule

// File: rtl/bob_retire.sv
// In-order retire of the BOB head once its completion mark is set,
// presented through a registered valid/ready output stage.
module bob_retire
    import bob_retire_pkg::*;
#(
    parameter int WIDTH      = BOB_WIDTH,
    parameter int ADDR_WIDTH = BOB_ADDR_WIDTH,
    parameter int COUNT      = BOB_COUNT
) (
    input  logic         clk,
    input  logic         rst,
    bob_retire_if.master bus
);

    logic [ADDR_WIDTH-1:0] head_q;
    logic                  head_done;
    logic                  do_retire;
    logic                  out_valid_q;
    logic [WIDTH-1:0]      out_data_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;

    // The RAM registers retire_addr, so read_data this cycle belongs to head_q.
    assign bus.read_clkEn = ~rst;
    assign bus.read_addr  = bus.retire_addr;

    assign do_retire = bus.hasRetire & head_done & ~bus.except & ~rst
                     & (~out_valid_q | bus.out_ready);
    assign bus.doRetire = do_retire;

    bob_done_vec #(
        .COUNT      (COUNT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_done (
        .clk      (clk),
        .rst      (rst),
        .clr_all  (bus.except),
        .set_en   (bus.done_en),
        .set_addr (bus.done_addr),
        .clr_en   (do_retire),
        .clr_addr (head_q),
        .rd_addr  (head_q),
        .rd_bit   (head_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            head_q <= bus.retire_addr;
            // A retire in the same cycle as a consume reloads without a bubble.
            if (do_retire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.read_data;
                out_addr_q  <= head_q;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;

endmodule

// File: tb/tb_bob_retire.sv
// Bench for bob_retire: allocator + registered RAM model, vector table, and an
// in-order scoreboard filled at allocation time and drained on output handshakes.
module tb_bob_retire;
    import bob_retire_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bob_retire_if #(.WIDTH(32), .ADDR_WIDTH(6)) bus ();

    bob_retire dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;

    logic [5:0] alloc_head;
    int         cnt;
    logic       alloc_pulse;
    logic [5:0] new_addr;
    logic [5:0] tail;
    bob_out_t   sbq[$];
    int         rc;

    function automatic logic [5:0] nxt(input logic [5:0] a);
        return (a == 6'd47) ? 6'd0 : a + 6'd1;
    endfunction

    function automatic logic [31:0] memv(input logic [5:0] a);
        return {16'hB0B0, 2'b00, a, 2'b11, ~a};
    endfunction

    // Allocator model: combinational next-head including this cycle's pop/flush.
    assign bus.retire_addr = bus.except ? new_addr
                           : (bus.doRetire ? nxt(alloc_head) : alloc_head);
    assign bus.hasRetire = (cnt != 0);

    always @(posedge clk) begin
        if (rst) begin
            alloc_head <= 6'd0;
            cnt        <= 0;
        end else if (bus.except) begin
            alloc_head <= new_addr;
            cnt        <= 0;
        end else begin
            alloc_head <= bus.doRetire ? nxt(alloc_head) : alloc_head;
            cnt        <= cnt + (alloc_pulse ? 1 : 0) - (bus.doRetire ? 1 : 0);
        end
    end

    always @(posedge clk)
        if (bus.read_clkEn) bus.read_data <= memv(bus.read_addr);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic sb_mon();
        bit       fire;
        bob_out_t e;
        fire = bus.out_valid && bus.out_ready;
        if (fire) begin
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_underflow got addr=%0d want=no output", bus.out_addr);
            end else begin
                e = sbq.pop_front();
                chk("sb_addr", 64'(bus.out_addr), 64'(e.addr));
                chk("sb_data", 64'(bus.out_data), 64'(e.data));
            end
        end
        rc = rc + (bus.doRetire ? 1 : 0) - (fire ? 1 : 0);
        // Flush: only an entry already sitting in the output stage survives.
        if (bus.except)
            while (sbq.size() > rc) void'(sbq.pop_back());
    endtask

    task automatic alloc_drive();
        alloc_pulse = 1'b1;
        sbq.push_back('{addr: tail, data: memv(tail)});
        tail = nxt(tail);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        alloc_pulse  = 1'b0;
        bus.done_en  = 1'b0;
        bus.except   = 1'b0;
    endtask

    // One cycle: drive, sample at negedge, compare (-1 = skip), advance.
    task automatic run(input int al, input int den, input int dad, input int rdy,
                       input int edr, input int eov, input string nm);
        if (al != 0) alloc_drive();
        bus.done_en   = (den != 0);
        bus.done_addr = 6'(dad);
        bus.out_ready = (rdy != 0);
        @(negedge clk);
        sb_mon();
        if (edr >= 0) chk({nm, "_dr"}, 64'(bus.doRetire), 64'(edr));
        if (eov >= 0) chk({nm, "_ov"}, 64'(bus.out_valid), 64'(eov));
        adv();
    endtask

    typedef struct {
        int al, den, dad, rdy, dr, ov, oa;
    } vec_t;
    vec_t tv [25];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tv = '{
            '{1,0,0,1,0,0,0}, '{1,0,0,1,0,0,0}, '{1,0,0,1,0,0,0}, '{1,0,0,1,0,0,0},
            '{1,0,0,1,0,0,0}, '{1,0,0,1,0,0,0}, '{1,0,0,1,0,0,0}, '{1,0,0,1,0,0,0},
            '{0,1,0,1,0,0,0}, '{0,1,1,1,1,0,0}, '{0,1,2,1,1,1,0}, '{0,1,3,1,1,1,1},
            '{0,1,4,1,1,1,2}, '{0,0,0,1,1,1,3}, '{0,1,5,1,0,1,4}, '{0,0,0,1,1,0,0},
            '{0,0,0,1,0,1,5}, '{0,0,0,1,0,0,0}, '{0,1,6,0,0,0,0}, '{0,1,7,0,1,0,0},
            '{0,0,0,0,0,1,6}, '{0,0,0,0,0,1,6}, '{0,0,0,1,1,1,6}, '{0,0,0,1,0,1,7},
            '{0,0,0,1,0,0,0}
        };
        rst = 1'b1;
        bus.except = 1'b0;
        bus.done_en = 1'b0;
        bus.done_addr = 6'd0;
        bus.out_ready = 1'b0;
        alloc_pulse = 1'b0;
        new_addr = 6'd0;
        tail = 6'd0;
        rc = 0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_dr",    64'(bus.doRetire),   64'd0);
        chk("rst_clken", 64'(bus.read_clkEn), 64'd0);
        chk("rst_ov",    64'(bus.out_valid),  64'd0);
        chk("rst_addr",  64'(bus.out_addr),   64'd0);
        chk("rst_data",  64'(bus.out_data),   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("clken", 64'(bus.read_clkEn), 64'd1);
        adv();

        // Idle-not-done, single retire timing at head 5, backpressure and no-bubble reload.
        for (int i = 0; i < 25; i++) begin
            if (tv[i].al != 0) alloc_drive();
            bus.done_en   = (tv[i].den != 0);
            bus.done_addr = 6'(tv[i].dad);
            bus.out_ready = (tv[i].rdy != 0);
            @(negedge clk);
            sb_mon();
            chk($sformatf("tv%0d_dr", i), 64'(bus.doRetire), 64'(tv[i].dr));
            chk($sformatf("tv%0d_ov", i), 64'(bus.out_valid), 64'(tv[i].ov));
            if (tv[i].ov != 0)
                chk($sformatf("tv%0d_addr", i), 64'(bus.out_addr), 64'(tv[i].oa));
            adv();
        end

        // Flush with a pending output; done_en at the new head is ignored.
        run(1, 0, 0, 0, 0, -1, "x1");
        run(1, 1, 8, 0, 0, -1, "x2");
        run(0, 1, 9, 0, 1, -1, "x3");
        run(0, 0, 0, 0, 0,  1, "x4");
        bus.except = 1'b1; new_addr = 6'd9; tail = 6'd9;
        run(0, 1, 9, 0, 0,  1, "x5");
        run(1, 0, 0, 1, 0,  1, "x6");
        run(0, 0, 0, 1, 0,  0, "x7");
        run(0, 0, 0, 1, 0,  0, "x8");

        // Wrap 46,47,0 with three consecutive retires.
        bus.except = 1'b1; new_addr = 6'd46; tail = 6'd46;
        run(0, 0, 0, 1, 0, -1, "w0");
        run(1, 0, 0, 1, 0, -1, "w1");
        run(1, 0, 0, 1, 0, -1, "w2");
        run(1, 1, 47, 1, 0, -1, "w3");
        run(0, 1, 0, 1, 0, -1, "w4");
        run(0, 1, 46, 1, 0, -1, "w5");
        run(0, 0, 0, 1, 1, -1, "w6");
        run(0, 0, 0, 1, 1, -1, "w7");
        run(0, 0, 0, 1, 1, -1, "w8");
        run(0, 0, 0, 1, 0,  1, "w9");
        run(0, 0, 0, 1, 0, -1, "w10");

        // Out-of-range mark, then mark at head on the retire cycle (clear wins).
        run(1, 1, 50, 1, 0, -1, "d1");
        run(0, 0, 0, 1, 0, -1, "d2");
        run(0, 1, 1, 1, 0, -1, "d3");
        run(0, 1, 1, 1, 1, -1, "d4");
        run(0, 0, 0, 1, 0,  1, "d5");

        // Go once around the ring so head revisits entry 1.
        for (int k = 0; k < 47; k++)
            run(1, 1, (2 + k) % 48, 1, (k == 0) ? 0 : 1, -1, $sformatf("lp%0d", k));
        run(1, 0, 0, 1, 1, -1, "p1");
        run(0, 0, 0, 1, 0, -1, "p2");
        run(0, 0, 0, 1, 0, -1, "p3");
        run(0, 1, 1, 1, 0, -1, "p4");
        run(0, 0, 0, 1, 1, -1, "p5");
        run(0, 0, 0, 1, 0,  1, "p6");
        run(0, 0, 0, 1, 0,  0, "p7");
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        // Reset with an output pending drops it.
        run(1, 1, 2, 0, 0, -1, "s1");
        run(0, 0, 0, 0, 1, -1, "s2");
        @(negedge clk);
        chk("s3_ov", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        rc = 0;
        tail = 6'd0;
        @(negedge clk);
        chk("mrst_ov",   64'(bus.out_valid), 64'd0);
        chk("mrst_addr", 64'(bus.out_addr),  64'd0);
        chk("mrst_data", 64'(bus.out_data),  64'd0);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/bob_retire.md
Name: bob_retire

Overview:
- Read/retire end of the branch order buffer (48 entries).
- Consumes the head pointer and occupancy flag from the BOB address allocator and drives the BOB RAM read port.
- Tracks per-entry completion marks from the execute side; retires the head entry in order once it is complete.
- Presents each retired entry in a registered valid/ready output stage toward the retire/commit logic.

Parameters:
- WIDTH, `bob_width, BOB entry payload width.
- ADDR_WIDTH, `bob_addr_width (6), entry index width.
- COUNT, `bob_count (48), number of entries; index wraps COUNT-1 -> 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- except  in  1  pipeline flush from the allocator side.
- hasRetire  in  1  BOB non-empty (allocator cnt!=0).
- retire_addr  in  ADDR_WIDTH  allocator next-head index (combinational, already includes this cycle's doRetire/except).
- doRetire  out  1  pop head this cycle; fed back to allocator.
- read_clkEn  out  1  BOB RAM read address enable.
- read_addr  out  ADDR_WIDTH  BOB RAM read address.
- read_data  in  WIDTH  BOB RAM data for the registered read address.
- done_en  in  1  mark one entry complete.
- done_addr  in  ADDR_WIDTH  index to mark.
- out_valid  out  1  retired entry available.
- out_ready  in  1  consumer accepts the output.
- out_data  out  WIDTH  retired entry payload.
- out_addr  out  ADDR_WIDTH  retired entry index.

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - Reset values: out_valid=0, out_data=0, out_addr=0, head_q=0, done vector all 0.
  - doRetire is combinational and is 0 while rst is asserted.
- RAM read port:
  - read_clkEn = !rst; read_addr = retire_addr.
  - The RAM registers the address, so read_data in cycle t corresponds to head_q, the head for cycle t.
  - head_q <= retire_addr every cycle (0 on rst). This gives zero-bubble back-to-back retire.
- Done vector:
  - COUNT bits.
  - done_en with done_addr<COUNT sets bit done_addr at the next edge.
  - done_addr>=COUNT is ignored.
  - No bypass: an entry marked in cycle t is eligible from t+1.
- Retire condition (combinational): doRetire = hasRetire & done[head_q] & !except & !rst & (!out_valid | out_ready).
- On doRetire, at the next edge:
  - out_data<=read_data, out_addr<=head_q, out_valid<=1.
  - done[head_q] is cleared.
  - If done_en targets head_q in the same cycle, clear wins.
- Output handshake:
  - out_valid & out_ready without doRetire sets out_valid<=0.
  - With doRetire in the same cycle, the register reloads and out_valid stays 1.
  - out_data and out_addr hold while out_valid & !out_ready.
- Exception:
  - done vector is cleared to all 0 at the next edge; done_en in the except cycle is ignored.
  - doRetire is forced 0.
  - The output register is untouched (its entry is already architecturally retired) and drains normally.
  - head_q follows retire_addr (equal to the allocator's new_addr during except).
- Wrap: no local arithmetic on the head index; wrap at COUNT is the allocator's job.
- Empty: hasRetire=0 means no retire, regardless of stale done bits or RAM data.
- Reset mid-operation: all state returns to reset values at that edge; a pending output is dropped.

Decomposition:
- Widths and count come from the existing `bob_width, `bob_count and `bob_addr_width macros in struct.sv; no new package items.
- One sub-module: bob_done_vec.
  - COUNT-bit set/clear register with indexed read and global clear.
  - Ports: clk, rst, clr_all, set_en, set_addr, clr_en, clr_addr, rd_addr, rd_bit.
  - Clear has priority over set.

Test Plan:
- Reset, hasRetire=1, done vector all 0 -> doRetire=0 and out_valid=0 indefinitely.
- Head at 5 with read_data=D; done_en@5 in cycle t -> doRetire=1 in t+1; out_valid=1, out_addr=5, out_data=D in t+2; bit 5 cleared.
- Entries 46,47,0 all done, out_ready=1 -> doRetire high 3 consecutive cycles; out_addr sequence 46,47,0 (wrap).
- out_valid=1, out_ready=0, head done -> doRetire=0 and out_data held; raising out_ready -> doRetire=1 the same cycle, output reloads, no bubble.
- Entries 3,4 done, except pulsed -> doRetire=0 in that cycle; done vector 0 afterwards; a pending out_valid entry is still delivered.
- done_en with done_addr=50 -> no bit set; done_en at head_q in the same cycle as its retire -> bit ends 0, entry retired exactly once.
